apple1_char_sender: RTL
=======================

Name: apple1_char_sender

Overview:
- Initiator side of the Apple-1 terminal character interface: buffers 7-bit ASCII characters from the host (PIA/CPU side) and delivers them one at a time to the video terminal using the DA/RDA strobe handshake.
- Sits between the PIA output-port model and the terminal's character input latch, which samples the data bus while DA is high.
- Contains a small synchronous FIFO plus a 3-state handshake FSM.

Parameters:
- DEPTH_LOG2, 3, log2 of FIFO depth (8 entries); legal range 1..6.
- DATA_W, 7, character width in bits; fixed at 7 for Apple-1 ASCII.

Ports:
- clk  input  1  system clock; all logic on its rising edge.
- mr_n  input  1  asynchronous active-low master reset.
- wr_en  input  1  host write strobe; accepted only when full==0.
- wr_data  input  DATA_W  character to enqueue.
- full  output  1  FIFO holds 2**DEPTH_LOG2 entries.
- level  output  DEPTH_LOG2+1  current FIFO occupancy.
- rda  input  1  terminal ready (1 = ready, 0 = busy/accepting); synchronous to clk.
- da  output  1  data-available strobe to the terminal.
- dout  output  DATA_W  character presented to the terminal; stable for the whole time da==1.

Behaviour:
- Reset, asynchronous on negedge mr_n and overriding everything, also applies at time zero:
  - da=0, dout=0, level=0, full=0.
  - FSM goes to IDLE; FIFO pointers are zeroed.
  - A reset mid-handshake drops da immediately and discards all queued data.
- FIFO:
  - The write is accepted on the clk edge when wr_en && !full.
  - A write while full is dropped silently; level is unchanged.
  - full and level are registered and reflect the state after the current edge.
  - Pointers wrap modulo depth.
  - On a simultaneous write and pop, level is unchanged. When full, the write is still rejected because full is evaluated before the pop.
- FSM states IDLE, PRESENT, RELEASE:
  - IDLE: if level!=0 && rda==1, pop the head into dout, set da=1 and go to PRESENT (registered: da rises on this edge). Otherwise stay.
  - PRESENT: hold da=1 and dout. When rda==0, set da=0 and go to RELEASE.
  - RELEASE: da=0 and dout held. When rda==1, go to IDLE.
- Latency: a character written at edge N into an empty FIFO, with rda==1, appears on dout with da=1 at edge N+1.
- Back-to-back throughput: at most one character per 3 edges when rda toggles each cycle.
- rda==0 while in IDLE: no pop; wait.
- rda must fall before da drops; da never drops without an observed rda low.
- dout changes only on the IDLE->PRESENT edge.

Optional Feature:
- Macro: APPLE1_SENDER_UPCASE_EN.
- Defined: characters 0x61..0x7A are folded to 0x41..0x5A (bit 5 cleared) at enqueue time; all other codes pass unchanged. The Apple-1 character ROM has no lowercase glyphs.
- Undefined: characters are stored and sent verbatim.
- level/full accounting is identical in both builds.

Decomposition:
- Shared package/header apple1_term_pkg:
  - FSM state encoding (IDLE=2'd0, PRESENT=2'd1, RELEASE=2'd2).
  - ASCII constants: CR=7'h0D, ASCII_A_LC=7'h61, ASCII_Z_LC=7'h7A, CASE_BIT=5.
- One sub-module: char_fifo (parameterised DATA_W/DEPTH_LOG2 synchronous FIFO with async active-low reset, level, full, empty).
- The FSM lives in apple1_char_sender.

Test Plan:
- Reset/idle check: assert mr_n=0 mid-PRESENT with 3 queued chars -> da=0, dout=0, level=0 immediately, without waiting for a clock; after release the FSM is in IDLE and da stays 0.
- Single character: rda=1, write 7'h48 at edge N -> dout=7'h48, da=1 at edge N+1. Drive rda=0 -> da=0 next edge. Drive rda=1 -> back in IDLE, level=0.
- Burst and order: write 0x41,0x42,0x43 consecutively while rda=1; terminal model responds with a 1-cycle rda pulse low per da -> dout sequence is 0x41,0x42,0x43 with no duplicates or drops.
- Full/overflow: hold rda=0, write 9 chars 0x30..0x38 -> full=1 after the 8th write, level=8, 0x38 dropped. Release rda -> exactly 0x30..0x37 delivered.
- Simultaneous write/pop:
  - level=1, IDLE, rda=1, write 0x0D on the pop edge -> level stays 1 and 0x0D is delivered next.
  - level=8 with a write on the pop edge -> write rejected, level becomes 7.
- Upcase option: write 0x61, 0x7A, 0x7B, 0x0D -> with APPLE1_SENDER_UPCASE_EN, dout is 0x41, 0x5A, 0x7B, 0x0D; without it, dout is 0x61, 0x7A, 0x7B, 0x0D.

Source files
------------

// File: rtl/apple1_term_pkg.sv
// Shared definitions for the Apple-1 terminal character path.
//   - state_t      : handshake FSM encoding used by apple1_char_sender
//   - ASCII consts : carriage return, lowercase range bounds and the bit that
//                    separates lowercase from uppercase letters
package apple1_term_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PRESENT = 2'd1,
        ST_RELEASE = 2'd2
    } state_t;

    localparam logic [6:0] CR         = 7'h0D;
    localparam logic [6:0] ASCII_A_LC = 7'h61;
    localparam logic [6:0] ASCII_Z_LC = 7'h7A;
    localparam int         CASE_BIT   = 5;

endpackage

// File: rtl/char_fifo.sv
// Synchronous FIFO holding characters waiting for the terminal.
// Ports:
//   clk      in   rising-edge clock
//   mr_n     in   asynchronous active-low reset (pointers, level, full)
//   wr_en    in   enqueue request; ignored while full
//   wr_data  in   character to enqueue
//   rd_en    in   dequeue request; ignored while empty
//   rd_data  out  head of queue (combinational, valid while !empty)
//   level    out  registered occupancy, 0..2**DEPTH_LOG2
//   full     out  registered, level == 2**DEPTH_LOG2
//   empty    out  level == 0
module char_fifo #(
    parameter int DATA_W     = 7,
    parameter int DEPTH_LOG2 = 3
) (
    input  logic                  clk,
    input  logic                  mr_n,
    input  logic                  wr_en,
    input  logic [DATA_W-1:0]     wr_data,
    input  logic                  rd_en,
    output logic [DATA_W-1:0]     rd_data,
    output logic [DEPTH_LOG2:0]   level,
    output logic                  full,
    output logic                  empty
);

    localparam int                DEPTH   = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] DEPTH_L = (DEPTH_LOG2+1)'(DEPTH);

    logic [DATA_W-1:0]     r_mem [DEPTH];
    logic [DEPTH_LOG2-1:0] r_wr_ptr;
    logic [DEPTH_LOG2-1:0] r_rd_ptr;
    logic [DEPTH_LOG2:0]   r_level;
    logic                  r_full;
    logic [DEPTH_LOG2:0]   w_level_nxt;
    logic                  w_push;
    logic                  w_pop;

    // Full is judged on the pre-edge state, so a write coinciding with a pop
    // from a full queue is still rejected.
    assign w_push = wr_en && !r_full;
    assign w_pop  = rd_en && (r_level != '0);

    always_comb begin
        w_level_nxt = r_level;
        if (w_push && !w_pop)
            w_level_nxt = r_level + 1'b1;
        else if (w_pop && !w_push)
            w_level_nxt = r_level - 1'b1;
    end

    // Pointers are exactly DEPTH_LOG2 bits wide, so they wrap by overflow.
    always_ff @(posedge clk or negedge mr_n) begin
        if (!mr_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
            r_full   <= 1'b0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            r_level <= w_level_nxt;
            r_full  <= (w_level_nxt == DEPTH_L);
        end
    end

    // Storage needs no reset: a slot is only read after it has been written.
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= wr_data;
    end

    assign rd_data = r_mem[r_rd_ptr];
    assign level   = r_level;
    assign full    = r_full;
    assign empty   = (r_level == '0);

endmodule

// File: rtl/apple1_char_sender.sv
// Initiator side of the Apple-1 terminal character interface. Buffers host
// characters in a FIFO and hands them to the terminal one at a time with the
// DA/RDA strobe handshake: da rises with a new dout, the terminal pulls rda
// low to take it, da falls, and the next character waits for rda to return.
// Ports:
//   clk      in   rising-edge clock
//   mr_n     in   asynchronous active-low master reset
//   wr_en    in   host write strobe (dropped while full)
//   wr_data  in   character from host
//   full     out  FIFO full (registered)
//   level    out  FIFO occupancy (registered)
//   rda      in   terminal ready, synchronous to clk
//   da       out  data-available strobe
//   dout     out  character to terminal, held while da==1
// Build option: APPLE1_SENDER_UPCASE_EN folds 'a'..'z' to 'A'..'Z' on enqueue.
module apple1_char_sender
    import apple1_term_pkg::*;
#(
    parameter int DEPTH_LOG2 = 3,
    parameter int DATA_W     = 7
) (
    input  logic                clk,
    input  logic                mr_n,
    input  logic                wr_en,
    input  logic [DATA_W-1:0]   wr_data,
    output logic                full,
    output logic [DEPTH_LOG2:0] level,
    input  logic                rda,
    output logic                da,
    output logic [DATA_W-1:0]   dout
);

    state_t            r_state;
    state_t            w_state_nxt;
    logic              r_da;
    logic [DATA_W-1:0] r_dout;
    logic [DATA_W-1:0] w_wr_data;
    logic [DATA_W-1:0] w_head;
    logic              w_empty;
    logic              w_pop;

    // The character ROM has no lowercase glyphs; optionally fold them here so
    // the queue only ever holds displayable codes.
    always_comb begin
        w_wr_data = wr_data;
`ifdef APPLE1_SENDER_UPCASE_EN
        if (wr_data >= ASCII_A_LC && wr_data <= ASCII_Z_LC)
            w_wr_data[CASE_BIT] = 1'b0;
`endif
    end

    char_fifo #(
        .DATA_W     (DATA_W),
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_fifo (
        .clk     (clk),
        .mr_n    (mr_n),
        .wr_en   (wr_en),
        .wr_data (w_wr_data),
        .rd_en   (w_pop),
        .rd_data (w_head),
        .level   (level),
        .full    (full),
        .empty   (w_empty)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_pop       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (!w_empty && rda) begin
                    w_pop       = 1'b1;
                    w_state_nxt = ST_PRESENT;
                end
            end
            ST_PRESENT: if (!rda) w_state_nxt = ST_RELEASE;
            ST_RELEASE: if (rda)  w_state_nxt = ST_IDLE;
            default:              w_state_nxt = ST_IDLE;
        endcase
    end

    // da is a pure register of "next state is PRESENT", so it rises on the
    // pop edge and falls on the edge that observes rda low.
    always_ff @(posedge clk or negedge mr_n) begin
        if (!mr_n) begin
            r_state <= ST_IDLE;
            r_da    <= 1'b0;
            r_dout  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_da    <= (w_state_nxt == ST_PRESENT);
            if (w_pop) r_dout <= w_head;
        end
    end

    assign da   = r_da;
    assign dout = r_dout;

endmodule
